// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: step encodings and the load clamp shared by the up/down counter.
package updown_counter_pkg;

    localparam logic [1:0] STEP_HOLD = 2'd0;
    localparam logic [1:0] STEP_INC  = 2'd1;
    localparam logic [1:0] STEP_DEC  = 2'd2;

    // Sized for the widest legal counter (32 bits) plus one guard bit.
    function automatic logic [32:0] clamp_load(input logic [32:0] value, input logic [32:0] max_val);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/updown_counter_mod_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus registered rising-edge strobe.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [2:0] sync_q, sync_d;
    logic       pulse_q, pulse_d;

    // sync_q[1] is the synchronized level, sync_q[2] its previous value.
    always_comb begin
        sync_d  = {sync_q[1:0], din};
        pulse_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised wrap/saturate up/down counter with load, clear and flags.
// Define UPDOWN_COUNTER_EDGE_DETECT_EN to synchronize and edge-detect the up/down inputs.
module updown_counter_mod
    import updown_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             down,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
);

    localparam logic [WIDTH:0] MAX_W = {1'b0, MAX_VAL};

    logic             up_e, down_e;
    logic [1:0]       step;
    logic [WIDTH:0]   inc_w, dec_w;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

`ifdef UPDOWN_COUNTER_EDGE_DETECT_EN
    sync_edge_detect u_up_edge   (.clk(clk), .rst_n(rst_n), .din(up),   .pulse(up_e));
    sync_edge_detect u_down_edge (.clk(clk), .rst_n(rst_n), .din(down), .pulse(down_e));
`else
    assign up_e   = up;
    assign down_e = down;
`endif

    assign step  = (up_e & ~down_e) ? STEP_INC : (down_e & ~up_e) ? STEP_DEC : STEP_HOLD;
    assign inc_w = {1'b0, count_q} + 1'b1;
    assign dec_w = {1'b0, count_q} - 1'b1;

    // Overflow is judged against MAX_VAL, underflow by the borrow bit.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = WIDTH'(clamp_load(33'(load_val), 33'(MAX_VAL)));
        end else if (step == STEP_INC) begin
            if (inc_w > MAX_W) begin
                count_d = sat_mode ? count_q : '0;
                wrap_d  = ~sat_mode;
            end else begin
                count_d = inc_w[WIDTH-1:0];
            end
        end else if (step == STEP_DEC) begin
            if (dec_w[WIDTH]) begin
                count_d = sat_mode ? count_q : MAX_VAL;
                wrap_d  = ~sat_mode;
            end else begin
                count_d = dec_w[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign at_max     = (count_q == MAX_VAL);
    assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: directed vector table plus corner sequences for updown_counter_mod.
module tb_updown_counter_mod;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       clear = 1'b0, load = 1'b0, up = 1'b0, down = 1'b0, sat_mode = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] count;
    logic       at_max, at_min, wrap_pulse;

    logic       l4_load = 1'b0, l4_up = 1'b0;
    logic [3:0] l4_val = '0;
    logic [3:0] l4_count;
    logic       l4_max, l4_min, l4_wrap;

    int n_chk = 0;
    int n_fail = 0;

    updown_counter_mod #(.WIDTH(8), .MAX_VAL(8'd9), .RESET_VAL(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
        .up(up), .down(down), .sat_mode(sat_mode), .count(count),
        .at_max(at_max), .at_min(at_min), .wrap_pulse(wrap_pulse)
    );

    updown_counter_mod #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(l4_load), .load_val(l4_val),
        .up(l4_up), .down(1'b0), .sat_mode(1'b0), .count(l4_count),
        .at_max(l4_max), .at_min(l4_min), .wrap_pulse(l4_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr, ld;
        logic [7:0] lv;
        logic       u, d, s;
        logic [7:0] c;
        logic       mx, mn, w;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic clr, logic ld, logic [7:0] lv, logic u, logic d, logic s,
                                logic [7:0] c, logic mx, logic mn, logic w);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lv = lv; v.u = u; v.d = d; v.s = s;
        v.c = c; v.mx = mx; v.mn = mn; v.w = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [7:0] c, input logic mx, input logic mn,
                             input logic w);
        chk({name, " count"}, 32'(count), 32'(c));
        chk({name, " at_max"}, 32'(at_max), 32'(mx));
        chk({name, " at_min"}, 32'(at_min), 32'(mn));
        chk({name, " wrap_pulse"}, 32'(wrap_pulse), 32'(w));
    endtask

    initial begin
        #12;
        chk_state("reset", 8'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-count.
        load = 1'b1; load_val = 8'd5;
        tick();
        load = 1'b0;
        chk_state("load5", 8'd5, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_state("async_rst", 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;

        // Reset beats a wrap that would happen on the next edge.
        load = 1'b1; load_val = 8'd9;
        tick();
        load = 1'b0; up = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_state("rst_pending", 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_state("rst_hold", 8'd0, 1'b0, 1'b1, 1'b0);
        up = 1'b0;
        #2 rst_n = 1'b1;
        tick();

`ifdef UPDOWN_COUNTER_EDGE_DETECT_EN
        up = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("edge_lat%0d", i), 32'(count), 32'd0);
        end
        tick();
        chk("edge_step", 32'(count), 32'd1);
        repeat (16) tick();
        chk("edge_held", 32'(count), 32'd1);
        up = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            up = 1'b1;
            repeat (2) tick();
            up = 1'b0;
            repeat (3) tick();
        end
        repeat (3) tick();
        chk("edge_pulses", 32'(count), 32'd4);
        up = 1'b1; down = 1'b1;
        repeat (6) tick();
        chk("edge_both", 32'(count), 32'd4);
        up = 1'b0; down = 1'b0;
        repeat (4) tick();
        down = 1'b1;
        repeat (4) tick();
        chk("edge_down", 32'(count), 32'd3);
        down = 1'b0;
        repeat (4) tick();
`else
        for (int i = 1; i <= 9; i++)
            vq.push_back(mk(0, 0, 0, 1, 0, 0, 8'(i), i == 9, 0, 0));
        vq.push_back(mk(0, 0, 0,   1, 0, 0, 8'd0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0,   0, 0, 0, 8'd0, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,   0, 1, 0, 8'd9, 1, 0, 1));
        vq.push_back(mk(0, 0, 0,   0, 1, 0, 8'd8, 0, 0, 0));
        vq.push_back(mk(0, 1, 9,   0, 0, 0, 8'd9, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,   1, 0, 1, 8'd9, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,   1, 0, 1, 8'd9, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,   1, 0, 1, 8'd9, 1, 0, 0));
        vq.push_back(mk(0, 1, 0,   0, 0, 1, 8'd0, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,   0, 1, 1, 8'd0, 0, 1, 0));
        vq.push_back(mk(0, 1, 4,   0, 0, 0, 8'd4, 0, 0, 0));
        vq.push_back(mk(1, 1, 7,   1, 0, 0, 8'd0, 0, 1, 0));
        vq.push_back(mk(0, 1, 200, 0, 0, 0, 8'd9, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,   1, 1, 0, 8'd9, 1, 0, 0));
        vq.push_back(mk(0, 1, 5,   0, 0, 0, 8'd5, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,   0, 1, 0, 8'd4, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,   1, 0, 0, 8'd5, 0, 0, 0));
        vq.push_back(mk(1, 0, 0,   0, 0, 0, 8'd0, 0, 1, 0));
        foreach (vq[i]) begin
            clear = vq[i].clr; load = vq[i].ld; load_val = vq[i].lv;
            up = vq[i].u; down = vq[i].d; sat_mode = vq[i].s;
            tick();
            chk_state($sformatf("vec%0d", i), vq[i].c, vq[i].mx, vq[i].mn, vq[i].w);
        end
        clear = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0; sat_mode = 1'b0;
`endif

        // Full-range 4-bit instance.
        l4_load = 1'b1; l4_val = 4'd15;
        tick();
        l4_load = 1'b0;
        chk("w4 load15", 32'(l4_count), 32'd15);
        chk("w4 at_max", 32'(l4_max), 32'd1);
        l4_up = 1'b1;
`ifdef UPDOWN_COUNTER_EDGE_DETECT_EN
        tick();
        l4_up = 1'b0;
        repeat (3) tick();
`else
        tick();
        l4_up = 1'b0;
`endif
        chk("w4 wrap count", 32'(l4_count), 32'd0);
        chk("w4 wrap pulse", 32'(l4_wrap), 32'd1);
        chk("w4 at_min", 32'(l4_min), 32'd1);
        tick();
        chk("w4 pulse end", 32'(l4_wrap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
